// File: rtl/num_set_pkg.sv
// num_set_pkg: shared BCD digit type, BCD maximum, load clamp helper and repeat FSM states
package num_set_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_st_t;
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_entry_btn_repeat.sv
// btn_repeat: edge detect of up/down/h/l (clk, rst_n, abort in) with IDLE/DELAY/REPEAT auto-repeat giving step_up/step_down/h_edge/l_edge pulses
module btn_repeat
    import num_set_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up,
    input  logic down,
    input  logic h,
    input  logic l,
    input  logic abort,
    output logic step_up,
    output logic step_down,
    output logic h_edge,
    output logic l_edge
);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    rep_st_t       state;
    logic [CW-1:0] cnt;
    logic          dir;
    logic [3:0]    btn, hist, lock, edg;
    logic          held, hold_ok, tick_hit, start_up, start_dn, rep_step;
    assign btn    = {l, h, down, up};
    assign edg    = btn & ~hist & ~lock;
    assign h_edge = edg[2];
    assign l_edge = edg[3];
    always_comb begin
        held      = dir ? down : up;
        hold_ok   = held && !(up && down);
        tick_hit  = (state == ST_DELAY) ? (cnt == CW'(REPEAT_DELAY)) : (cnt == CW'(REPEAT_RATE));
        start_up  = (state == ST_IDLE) && edg[0] && !down;
        start_dn  = (state == ST_IDLE) && edg[1] && !up;
        rep_step  = (state != ST_IDLE) && hold_ok && tick_hit;
        step_up   = !abort && (start_up || (rep_step && !dir));
        step_down = !abort && (start_dn || (rep_step && dir));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
            hist  <= '0;
            lock  <= '1;
        end else begin
            hist <= btn;
            lock <= lock & btn;
            if (abort || (state != ST_IDLE && !hold_ok)) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (start_up || start_dn) begin
                state <= ST_DELAY;
                cnt   <= CW'(1);
                dir   <= start_dn;
            end else if (rep_step) begin
                state <= ST_REPEAT;
                cnt   <= CW'(1);
            end else if (state != ST_IDLE) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/bcd_entry.sv
// bcd_entry: button-driven BCD entry (clk, rst_n, up/down/h/l buttons, load/load_data in; data, cursor, changed out)
module bcd_entry
    import num_set_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CARRY_MODE   = 0,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_button,
    input  logic                       down_button,
    input  logic                       h_button,
    input  logic                       l_button,
    input  logic                       load,
    input  logic [4*DIGITS-1:0]        load_data,
    output logic [4*DIGITS-1:0]        data,
    output logic [$clog2(DIGITS)-1:0]  cursor,
    output logic                       changed
);
    localparam int CB = $clog2(DIGITS);
    logic                step_up, step_down, h_edge, l_edge, carry, sat;
    logic [4*DIGITS-1:0] stepped, clamped, nxt;
    bcd_t                d;
    btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_rep (
        .clk      (clk),
        .rst_n    (rst_n),
        .up       (up_button),
        .down     (down_button),
        .h        (h_button),
        .l        (l_button),
        .abort    (load),
        .step_up  (step_up),
        .step_down(step_down),
        .h_edge   (h_edge),
        .l_edge   (l_edge)
    );
    always_comb begin
        stepped = data;
        clamped = '0;
        carry   = 1'b1;
        d       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = data[4*i +: 4];
            clamped[4*i +: 4] = bcd_clamp(load_data[4*i +: 4]);
            if ((CARRY_MODE == 0) ? (i == int'(cursor)) : (i >= int'(cursor) && carry)) begin
                stepped[4*i +: 4] = step_up ? ((d == BCD_MAX) ? 4'd0 : d + 4'd1)
                                            : ((d == 4'd0) ? BCD_MAX : d - 4'd1);
                carry = step_up ? (d == BCD_MAX) : (d == 4'd0);
            end
        end
        sat = (CARRY_MODE != 0) && carry;
        nxt = load ? clamped : ((step_up || step_down) && !sat) ? stepped : data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data    <= '0;
            cursor  <= '0;
            changed <= 1'b0;
        end else begin
            data    <= nxt;
            changed <= (nxt != data);
            if (h_edge && !l_edge)
                cursor <= (cursor == CB'(DIGITS - 1)) ? '0 : cursor + CB'(1);
            else if (l_edge && !h_edge)
                cursor <= (cursor == '0) ? CB'(DIGITS - 1) : cursor - CB'(1);
        end
    end
endmodule

// File: tb/tb_bcd_entry.sv
// tb_bcd_entry: directed plus random checks of bcd_entry in both carry modes against a value-level model
module tb_bcd_entry;
    localparam int RD = 4;
    localparam int RR = 2;
    logic        clk = 1'b0;
    logic        rst_n, up_button, down_button, h_button, l_button, load;
    logic [15:0] load_data;
    logic [15:0] d0, d1;
    logic [1:0]  c0, c1;
    logic        ch0, ch1;
    int          total = 0;
    int          bad = 0;
    int          m0[4];
    int          v1, mcur, act, t;
    bit          mch0, mch1;
    logic [3:0]  mhist, mlock;

    always #5 clk = ~clk;

    bcd_entry #(.DIGITS(4), .CARRY_MODE(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u0 (
        .clk(clk), .rst_n(rst_n), .up_button(up_button), .down_button(down_button),
        .h_button(h_button), .l_button(l_button), .load(load), .load_data(load_data),
        .data(d0), .cursor(c0), .changed(ch0));
    bcd_entry #(.DIGITS(4), .CARRY_MODE(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u1 (
        .clk(clk), .rst_n(rst_n), .up_button(up_button), .down_button(down_button),
        .h_button(h_button), .l_button(l_button), .load(load), .load_data(load_data),
        .data(d1), .cursor(c1), .changed(ch1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] pack0();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(m0[i]);
        return r;
    endfunction

    task automatic cyc();
        logic [3:0]  b, e, ld;
        logic [15:0] old0, old1;
        bit          su, sd;
        int          w, lv;
        b = {l_button, h_button, down_button, up_button};
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m0[i] = 0;
            v1 = 0; mcur = 0; mch0 = 0; mch1 = 0; act = 0; t = 0;
            mhist = '0; mlock = '1;
        end else begin
            e = b & ~mhist & ~mlock;
            su = 0; sd = 0;
            if (act != 0) begin
                if (!((act == 1) ? up_button : down_button) || (up_button && down_button)) act = 0;
                else begin
                    t++;
                    if (t == RD || (t > RD && (t - RD) % RR == 0)) begin
                        su = (act == 1); sd = (act == 2);
                    end
                end
            end else if (e[0] && !down_button) begin
                su = 1; act = 1; t = 0;
            end else if (e[1] && !up_button) begin
                sd = 1; act = 2; t = 0;
            end
            old0 = pack0();
            old1 = to_bcd(v1);
            if (load) begin
                act = 0;
                lv = 0;
                for (int i = 3; i >= 0; i--) begin
                    ld = load_data[4*i +: 4];
                    m0[i] = (ld > 9) ? 9 : int'(ld);
                    lv = lv * 10 + m0[i];
                end
                v1 = lv;
            end else if (su || sd) begin
                m0[mcur] = su ? (m0[mcur] + 1) % 10 : (m0[mcur] + 9) % 10;
                w = 1;
                for (int i = 0; i < mcur; i++) w = w * 10;
                if (su && v1 + w < 10000) v1 = v1 + w;
                if (sd && v1 >= w) v1 = v1 - w;
            end
            mch0 = (pack0() != old0);
            mch1 = (to_bcd(v1) != old1);
            if (e[2] && !e[3]) mcur = (mcur + 1) % 4;
            else if (e[3] && !e[2]) mcur = (mcur + 3) % 4;
            mhist = b;
            mlock = mlock & b;
        end
        @(posedge clk);
        #1;
        chk("data0", d0, pack0());
        chk("data1", d1, to_bcd(v1));
        chk("cursor0", c0, mcur);
        chk("cursor1", c1, mcur);
        chk("changed0", ch0, mch0);
        chk("changed1", ch1, mch1);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_data = v;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; up_button = 0; down_button = 0; h_button = 0; l_button = 0;
        load = 0; load_data = '0;
        repeat (2) cyc();
        chk("rst_data", d0, 16'h0000);
        chk("rst_cursor", c1, 0);
        chk("rst_changed", ch1, 0);
        rst_n = 1'b1;
        cyc();
        // wrap in mode 0, carry in mode 1
        do_load(16'h0009);
        up_button = 1; cyc();
        chk("wrap_d0", d0, 16'h0000);
        chk("wrap_ch0", ch0, 1);
        chk("carry_d1", d1, 16'h0010);
        up_button = 0; cyc();
        chk("wrap_ch0_once", ch0, 0);
        do_load(16'h0199);
        up_button = 1; cyc();
        chk("carry_199", d1, 16'h0200);
        up_button = 0; cyc();
        do_load(16'h9999);
        up_button = 1; cyc();
        chk("sat_d1", d1, 16'h9999);
        chk("sat_ch1", ch1, 0);
        up_button = 0; cyc();
        // auto-repeat timing
        do_load(16'h0000);
        for (int k = 0; k < 12; k++) begin
            up_button = 1; cyc();
            chk("repeat_step", ch0, (k == 0 || k == 4 || k == 6 || k == 8 || k == 10));
        end
        chk("repeat_total", d0, 16'h0005);
        up_button = 0; cyc();
        chk("release_nostep", ch0, 0);
        up_button = 1; cyc();
        chk("idle_after_release", ch0, 1);
        up_button = 0; cyc();
        // cursor
        l_button = 1; cyc();
        chk("cur_wrap_low", c0, 3);
        l_button = 0; cyc();
        h_button = 1; cyc();
        chk("cur_wrap_high", c0, 0);
        h_button = 0; cyc();
        h_button = 1; l_button = 1; cyc();
        chk("cur_both", c0, 0);
        h_button = 0; l_button = 0; cyc();
        h_button = 1; cyc();
        h_button = 0; cyc();
        do_load(16'h0000);
        h_button = 1; up_button = 1; cyc();
        chk("cur_step_old", d0, 16'h0010);
        chk("cur_after", c0, 2);
        h_button = 0; up_button = 0; cyc();
        // load while held
        up_button = 1; cyc();
        load = 1; load_data = 16'h12F4; cyc(); load = 0;
        chk("load_clamp", d0, 16'h1294);
        chk("load_ch", ch0, 1);
        repeat (6) cyc();
        chk("load_idle", d1, 16'h1294);
        chk("load_ch_once", ch0, 0);
        up_button = 0; cyc();
        // reset mid-repeat
        h_button = 1; cyc(); h_button = 0; cyc();
        up_button = 1; repeat (7) cyc();
        rst_n = 0; cyc();
        chk("rst_mid_data", d1, 16'h0000);
        chk("rst_mid_cursor", c0, 0);
        chk("rst_mid_changed", ch0, 0);
        rst_n = 1; repeat (8) cyc();
        chk("rst_held", d0, 16'h0000);
        up_button = 0; cyc();
        up_button = 1; cyc();
        chk("rst_repress", d0, 16'h0001);
        up_button = 0; cyc();
        // random
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(7) == 0) up_button = ~up_button;
            if ($urandom_range(7) == 0) down_button = ~down_button;
            if ($urandom_range(9) == 0) h_button = ~h_button;
            if ($urandom_range(9) == 0) l_button = ~l_button;
            load = ($urandom_range(39) == 0);
            load_data = 16'($urandom);
            rst_n = ($urandom_range(199) != 0);
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
